// File: rtl/isr_feeder_pkg.sv
// Shared types and widths for the ISR front-end: FSM state encoding and the
// captured output record.
package isr_pkg;

    localparam int VALUE_W  = 64;
    localparam int RESULT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_ARM   = 2'd2,
        ST_BUSY  = 2'd3
    } isr_feed_state_t;

    typedef struct packed {
        logic [VALUE_W-1:0]  value;
        logic [RESULT_W-1:0] result;
        logic                timeout;
    } isr_result_t;

endpackage

// File: rtl/isr_feeder_if.sv
// Bundle of every non-clock signal of isr_feeder. The master modport is the
// feeder itself, and the slave modport is its environment.
interface isr_feeder_if #(
    parameter int DEPTH = 4
) ();
    import isr_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    // Both ports use valid/ready. A transfer happens on a posedge where valid
    // and ready are both high. Valid is not withdrawn by a missing ready.
    // Payload is only meaningful while valid is high.
    logic                in_valid;
    logic                in_ready;
    logic [VALUE_W-1:0]  in_value;

    logic                isr_start;
    logic [VALUE_W-1:0]  isr_value;
    logic [RESULT_W-1:0] isr_result;
    logic                isr_done;

    logic                out_valid;
    logic                out_ready;
    logic [VALUE_W-1:0]  out_value;
    logic [RESULT_W-1:0] out_result;
    logic                out_timeout;

    logic                busy;
    logic [CNT_W-1:0]    count;
    isr_feed_state_t     dbg_state;

    modport master (
        input  in_valid, in_value, isr_result, isr_done, out_ready,
        output in_ready, isr_start, isr_value, out_valid, out_value,
               out_result, out_timeout, busy, count, dbg_state
    );

    modport slave (
        output in_valid, in_value, isr_result, isr_done, out_ready,
        input  in_ready, isr_start, isr_value, out_valid, out_value,
               out_result, out_timeout, busy, count, dbg_state
    );

endinterface

// File: rtl/isr_feeder_fifo.sv
// Circular-buffer operand FIFO for the ISR feeder. Its count register is the
// only source for full and empty, so neither flag depends on same-cycle push or pop.
module isr_fifo
    import isr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = VALUE_W
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         i_push,
    input  logic [W-1:0]                 i_data,
    input  logic                         i_pop,
    output logic [W-1:0]                 o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/isr_feeder.sv
// Dispatches buffered operands to the ISR one job at a time and captures each
// result, or a watchdog abort, into a single-entry output register.
module isr_feeder
    import isr_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 128
) (
    input logic          clock,
    input logic          reset,
    isr_feeder_if.master bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

    isr_feed_state_t    r_state;
    isr_feed_state_t    w_next;
    logic               w_push;
    logic               w_pop;
    logic               w_capture;
    logic               w_abort;
    logic               w_full;
    logic               w_empty;
    logic [VALUE_W-1:0] w_head;
    logic [CNT_W-1:0]   w_count;
    logic [VALUE_W-1:0] r_isr_value;
    logic [WD_W-1:0]    r_wdog;
    isr_result_t        r_out;
    logic               r_out_valid;

    assign w_push = bus.in_valid & ~w_full;

    isr_fifo #(
        .DEPTH (DEPTH),
        .W     (VALUE_W)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (bus.in_value),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Dispatch waits for an empty output register, so a capture can never
    // overwrite a result that has not been read.
    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_capture = 1'b0;
        w_abort   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && !r_out_valid) begin
                    w_pop  = 1'b1;
                    w_next = ST_START;
                end
            end
            ST_START: w_next = ST_ARM;
            ST_ARM: begin
                if (r_wdog == WD_LIMIT) begin
                    w_abort = 1'b1;
                    w_next  = ST_IDLE;
                end else if (!bus.isr_done) begin
                    w_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.isr_done) begin
                    w_capture = 1'b1;
                    w_next    = ST_IDLE;
                end else if (r_wdog == WD_LIMIT) begin
                    w_abort = 1'b1;
                    w_next  = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_isr_value <= '0;
            r_wdog      <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_pop) begin
                r_isr_value <= w_head;
                r_wdog      <= '0;
            end else if (r_state != ST_IDLE && r_wdog != WD_LIMIT) begin
                r_wdog <= r_wdog + 1'b1;
            end
            if (w_capture) begin
                r_out       <= '{value: r_isr_value, result: bus.isr_result, timeout: 1'b0};
                r_out_valid <= 1'b1;
            end else if (w_abort) begin
                r_out       <= '{value: r_isr_value, result: '0, timeout: 1'b1};
                r_out_valid <= 1'b1;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = ~w_full;
    assign bus.isr_start   = (r_state == ST_START);
    assign bus.isr_value   = r_isr_value;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_value   = r_out.value;
    assign bus.out_result  = r_out.result;
    assign bus.out_timeout = r_out.timeout;
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.count       = w_count;
    assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_isr_feeder.sv
// Bench for isr_feeder. A behavioural ISR model stands in for the ISR, and a
// scoreboard checks every output transfer in order.
module tb_isr_feeder;
    import isr_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic [63:0] v;
        logic [31:0] r;
        logic        to;
        logic        prop;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    isr_feeder_if #(.DEPTH(DEPTH)) bus ();

    isr_feeder #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    bit   rand_ready = 0;
    bit   stuck = 0;

    // ISR stand-in: isr_start restarts it; done rises a few cycles later and stays high.
    logic        m_done   = 1'b0;
    logic [31:0] m_result = '0;
    logic [63:0] m_job    = '0;
    int          m_lat    = 0;
    assign bus.isr_done   = m_done;
    assign bus.isr_result = m_result;

    function automatic logic [31:0] isqrt(input logic [63:0] v);
        logic [31:0] r;
        logic [31:0] t;
        r = '0;
        for (int b = 31; b >= 0; b--) begin
            t = r | (32'd1 << b);
            if ({32'd0, t} * {32'd0, t} <= v) r = t;
        end
        return r;
    endfunction

    always @(posedge clock) begin
        if (bus.isr_start) begin
            m_done <= 1'b0;
            m_job  <= bus.isr_value;
            m_lat  <= $urandom_range(2, 10);
        end else if (m_lat != 0) begin
            m_lat <= m_lat - 1;
            if (m_lat == 1 && !stuck) begin
                m_done   <= 1'b1;
                m_result <= isqrt(m_job);
            end
        end
    end

    // Monitor and scoreboard.
    int          cyc = 0;
    int          start_hi = 0;
    int          start_rise = 0;
    int          last_start_cyc = 0;
    int          last_ov_cyc = 0;
    bit          prev_start = 0;
    bit          prev_ov = 0;
    logic [63:0] job_val = '0;
    exp_t        e;
    logic [64:0] sq_lo;
    logic [64:0] sq_hi;
    bit          res_ok;

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            if (bus.isr_start) begin
                start_hi++;
                if (!prev_start) start_rise++;
                job_val        = bus.isr_value;
                last_start_cyc = cyc;
            end else if (bus.busy) begin
                n_cmp++;
                if (bus.isr_value !== job_val) begin
                    n_fail++;
                    $display("FAIL isr_value_stable: got %h want %h", bus.isr_value, job_val);
                end
            end
            prev_start = bus.isr_start;
            if (bus.out_valid && !prev_ov) last_ov_cyc = cyc;
            prev_ov = bus.out_valid;
            if (bus.out_valid && bus.out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got value %h with no output pending", bus.out_value);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_value !== e.v) begin
                        n_fail++;
                        $display("FAIL sb_value: got %h want %h", bus.out_value, e.v);
                    end
                    n_cmp++;
                    if (bus.out_timeout !== e.to) begin
                        n_fail++;
                        $display("FAIL sb_timeout: got %b want %b", bus.out_timeout, e.to);
                    end
                    n_cmp++;
                    if (e.prop) begin
                        sq_lo  = {33'd0, bus.out_result} * {33'd0, bus.out_result};
                        sq_hi  = ({33'd0, bus.out_result} + 65'd1) * ({33'd0, bus.out_result} + 65'd1);
                        res_ok = (sq_lo <= {1'b0, e.v}) && (sq_hi > {1'b0, e.v});
                        if (!res_ok) begin
                            n_fail++;
                            $display("FAIL sb_sqrt_bound: got %h, not floor(sqrt(%h))", bus.out_result, e.v);
                        end
                    end else if (bus.out_result !== e.r) begin
                        n_fail++;
                        $display("FAIL sb_result: got %h want %h (value %h)", bus.out_result, e.r, e.v);
                    end
                end
            end
        end else begin
            prev_start = 0;
            prev_ov    = 0;
        end
    end

    // Driver tasks. Inputs change #1 after posedge; the DUT is sampled on negedge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_val(input logic [63:0] v, input logic [31:0] r, input bit to,
                            input bit prop, input int max_cyc, output bit ok);
        bit rdy;
        ok = 0;
        bus.in_valid = 1'b1;
        bus.in_value = v;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clock);
            rdy = bus.in_ready;
            tick();
            if (rand_ready) bus.out_ready = ($urandom_range(0, 1) == 1);
            if (rdy) begin
                ok = 1;
                exp_q.push_back('{v: v, r: r, to: to, prop: prop});
                break;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_value = {$urandom, $urandom};
    endtask

    task automatic wait_idle(input string name);
        bit idle_ok;
        idle_ok = 0;
        for (int i = 0; i < 400 && !idle_ok; i++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && !bus.busy && !bus.out_valid && bus.count == 0) idle_ok = 1;
        end
        tick();
        if (!idle_ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_drain: %0d results still pending, want 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({bus.in_ready, bus.isr_start, bus.busy, bus.count} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_ctrl: in_ready=%b isr_start=%b busy=%b count=%0d want 1 0 0 0",
                     bus.in_ready, bus.isr_start, bus.busy, bus.count);
        end
        n_cmp++;
        if ({bus.out_valid, bus.out_value, bus.out_result, bus.out_timeout} !== '0) begin
            n_fail++;
            $display("FAIL reset_out: valid=%b value=%h result=%h timeout=%b want all 0",
                     bus.out_valid, bus.out_value, bus.out_result, bus.out_timeout);
        end
        n_cmp++;
        if (bus.isr_value !== 64'd0 || bus.dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_fsm: isr_value=%h state=%0d want 0 IDLE", bus.isr_value, bus.dbg_state);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int s_hi;
        int s_rise;
        bit ok;
        s_hi   = start_hi;
        s_rise = start_rise;
        bus.out_ready = 1'b1;
        push_val(64'h1001, 32'h40, 1'b0, 1'b0, 20, ok);
        wait_idle("single");
        n_cmp++;
        if (start_hi - s_hi != 1 || start_rise - s_rise != 1) begin
            n_fail++;
            $display("FAIL single_start_pulse: high %0d cycles in %0d pulses, want 1 in 1",
                     start_hi - s_hi, start_rise - s_rise);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bus.out_ready = 1'b1;
        push_val(64'd0, 32'd0, 1'b0, 1'b0, 20, ok);
        push_val(64'd400, 32'd20, 1'b0, 1'b0, 20, ok);
        push_val(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 20, ok);
        wait_idle("back_to_back");
    endtask

    task automatic test_full();
        int s_rise;
        bit ok;
        logic [63:0] vals [6];
        logic [31:0] roots [6];
        vals  = '{64'd25, 64'd36, 64'd49, 64'd64, 64'd81, 64'd100};
        roots = '{32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10};
        s_rise = start_rise;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_val(vals[i], roots[i], 1'b0, 1'b0, 20, ok);
            n_cmp++;
            if (ok !== 1'b1) begin
                n_fail++;
                $display("FAIL full_accept_%0d: accepted=%b want 1", i, ok);
            end
        end
        push_val(vals[5], roots[5], 1'b0, 1'b0, 20, ok);
        n_cmp++;
        if (ok !== 1'b0) begin
            n_fail++;
            $display("FAIL full_sixth_blocked: accepted=%b want 0", ok);
        end
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.count !== 3'd4) begin
            n_fail++;
            $display("FAIL full_flags: in_ready=%b count=%0d want 0 4", bus.in_ready, bus.count);
        end
        n_cmp++;
        if (bus.out_valid !== 1'b1 || start_rise - s_rise != 1) begin
            n_fail++;
            $display("FAIL full_dispatch_blocked: out_valid=%b dispatches=%0d want 1 1",
                     bus.out_valid, start_rise - s_rise);
        end
        bus.out_ready = 1'b1;
        wait_idle("full");
    endtask

    task automatic test_timeout();
        bit ok;
        bit seen;
        int delta;
        bus.out_ready = 1'b1;
        stuck = 1;
        push_val(64'd9, 32'd0, 1'b1, 1'b0, 20, ok);
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clock);
            #1;
            if (bus.out_valid) seen = 1;
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL timeout_wait: out_valid=0 after 60 cycles, want 1");
        end else begin
            // Counter starts at 0 in START and aborts when it reaches TIMEOUT in ARM/BUSY.
            delta = last_ov_cyc - last_start_cyc;
            if (delta < TIMEOUT || delta > TIMEOUT + 2) begin
                n_fail++;
                $display("FAIL timeout_latency: got %0d cycles start->out_valid, want %0d..%0d",
                         delta, TIMEOUT, TIMEOUT + 2);
            end
        end
        tick();
        stuck = 0;
        push_val(64'd49, 32'd7, 1'b0, 1'b0, 20, ok);
        wait_idle("timeout");
    endtask

    task automatic test_mid_reset();
        bit ok;
        bit seen;
        bus.out_ready = 1'b1;
        push_val(64'd1000, 32'd31, 1'b0, 1'b0, 20, ok);
        push_val(64'd2000, 32'd44, 1'b0, 1'b0, 20, ok);
        push_val(64'd3000, 32'd54, 1'b0, 1'b0, 20, ok);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (bus.dbg_state == ST_BUSY) seen = 1;
        end
        n_cmp++;
        if (!seen || bus.count !== 3'd2) begin
            n_fail++;
            $display("FAIL midrst_setup: busy_seen=%b count=%0d want 1 2", seen, bus.count);
        end
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        n_cmp++;
        if ({bus.in_ready, bus.isr_start, bus.busy, bus.count, bus.isr_value} !== {1'b1, 1'b0, 1'b0, 3'd0, 64'd0}) begin
            n_fail++;
            $display("FAIL midrst_ctrl: in_ready=%b isr_start=%b busy=%b count=%0d isr_value=%h want 1 0 0 0 0",
                     bus.in_ready, bus.isr_start, bus.busy, bus.count, bus.isr_value);
        end
        n_cmp++;
        if ({bus.out_valid, bus.out_value, bus.out_result, bus.out_timeout} !== '0) begin
            n_fail++;
            $display("FAIL midrst_out: valid=%b value=%h result=%h timeout=%b want all 0",
                     bus.out_valid, bus.out_value, bus.out_result, bus.out_timeout);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        tick();
        push_val(64'd144, 32'd12, 1'b0, 1'b0, 20, ok);
        wait_idle("mid_reset");
    endtask

    task automatic test_random();
        bit ok;
        logic [63:0] v;
        rand_ready = 1;
        for (int i = 0; i < 20; i++) begin
            if (i == 7) begin
                push_val(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 200, ok);
            end else begin
                v = {$urandom, $urandom};
                v = v >> $urandom_range(0, 63);
                push_val(v, 32'd0, 1'b0, 1'b1, 200, ok);
            end
            if (!ok) begin
                n_cmp++;
                n_fail++;
                $display("FAIL random_push_%0d: accepted=0 want 1", i);
            end
        end
        rand_ready = 0;
        bus.out_ready = 1'b1;
        wait_idle("random");
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_value  = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_timeout();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation exceeded 40000 cycles");
        $fatal(1, "bench stopped");
    end

endmodule
